// File: rtl/puf_response_collector.sv
// puf_response_collector
//   Steps the challenge LFSR, latches each challenge onto the RO-pair select,
//   launches one RO race per challenge and shifts the returned comparison bit
//   into a response word. After RESP_BITS challenges the word is offered on
//   resp_valid/resp_ready.
//   Handshake: resp_valid rises only in DONE and stays high with resp_data
//   stable until a cycle with resp_ready=1; the transfer happens on that
//   clock edge and resp_valid drops on the next cycle.
//   Optional feature: define PUF_TIMEOUT_EN to add the WAIT timeout and the
//   sticky err flag (TIMEOUT_CYC exists only in that build).
//   dbg_state exposes the FSM state register for checkers.
module puf_response_collector #(
    parameter int RESP_BITS = 16,
    parameter int CHAL_W    = 4
`ifdef PUF_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAL_W-1:0]    chal_in,
    output logic                 lfsr_enable,
    output logic [CHAL_W-1:0]    ro_sel,
    output logic                 meas_start,
    input  logic                 meas_done,
    input  logic                 meas_bit,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 busy,
    output logic                 err,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_STEP   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    localparam int CNT_W = $clog2(RESP_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_BITS);

    state_e                state_q, state_d;
    logic [CHAL_W-1:0]     ro_sel_q, ro_sel_d;
    logic [RESP_BITS-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout;
    logic                  err_flag;

`ifdef PUF_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;

    // Timer counts WAIT cycles and is zero whenever WAIT is (re)entered.
    always_comb begin
        timer_d = (state_q == S_WAIT) ? timer_q + TMR_W'(1) : '0;
    end

    // A meas_done in the last allowed cycle takes priority over the timeout.
    assign timeout = (state_q == S_WAIT) && !meas_done && (timer_q == TMR_LAST);

    // err is sticky: set by a timeout, cleared only by the next accepted start.
    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && start) err_d = 1'b0;
        if (timeout)                    err_d = 1'b1;
    end

    // Timer and error flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign err_flag = err_q;
`else
    assign timeout  = 1'b0;
    assign err_flag = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start, meas_done and resp_ready only matter in their own state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LATCH;
            S_LATCH:  state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (meas_done)    state_d = S_STEP;
                else if (timeout) state_d = S_IDLE;
            end
            S_STEP:   state_d = (cnt_q == CNT_LAST) ? S_DONE : S_LATCH;
            S_DONE:   if (resp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next values: challenge latch, response shift register, bit count.
    always_comb begin
        ro_sel_d = ro_sel_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        if (state_q == S_IDLE && start) begin
            shreg_d = '0;
            cnt_d   = '0;
        end
        if (state_q == S_LATCH) ro_sel_d = chal_in;
        if (state_q == S_WAIT && meas_done) begin
            shreg_d = {shreg_q[RESP_BITS-2:0], meas_bit};
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ro_sel_q <= '0;
            shreg_q  <= '0;
            cnt_q    <= '0;
        end else begin
            ro_sel_q <= ro_sel_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decoded from registers only; resp_data is masked outside DONE so a
    // partial word is never visible.
    always_comb begin
        lfsr_enable = (state_q == S_STEP);
        meas_start  = (state_q == S_LAUNCH);
        resp_valid  = (state_q == S_DONE);
        busy        = (state_q != S_IDLE);
        resp_data   = (state_q == S_DONE) ? shreg_q : '0;
        ro_sel      = ro_sel_q;
        err         = err_flag;
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_puf_response_collector.sv
// Bench for puf_response_collector (RESP_BITS=4, CHAL_W=4, TIMEOUT_CYC=8).
// The bench owns a 4-bit LFSR model driving chal_in and an RO measurement
// model answering meas_start after a configurable latency.
module tb_puf_response_collector;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] chal_in;
    logic       lfsr_enable;
    logic [3:0] ro_sel;
    logic       meas_start;
    logic       meas_done;
    logic       meas_bit;
    logic [3:0] resp_data;
    logic       resp_valid;
    logic       resp_ready;
    logic       busy;
    logic       err;
    logic [2:0] dbg_state;

    puf_response_collector #(
        .RESP_BITS(4),
        .CHAL_W(4)
`ifdef PUF_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(8)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .chal_in(chal_in),
        .lfsr_enable(lfsr_enable),
        .ro_sel(ro_sel),
        .meas_start(meas_start),
        .meas_done(meas_done),
        .meas_bit(meas_bit),
        .resp_data(resp_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .busy(busy),
        .err(err),
        .dbg_state(dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] seed;
        int         lat;
        bit         inv;
        bit         spur;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[5];

    // Models and scoreboard state.
    logic [3:0] lfsr_m;
    int         countdown;
    int         lat_cfg;
    bit         inv_cfg;
    bit         spurious_en;
    bit         mute;
    logic       pend_bit;
    int         pulse_cnt;
    logic [3:0] asm_word;
    int         asm_n;
    logic [3:0] exp_q[$];
    int         total;
    int         bad;
    bit         got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ro_sel"}, ro_sel, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_lfsr_enable"}, lfsr_enable, 0);
        check({tag, "_meas_start"}, meas_start, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic reset_model();
        countdown = 0;
        asm_n     = 0;
        asm_word  = '0;
        pulse_cnt = 0;
        meas_done = 1'b0;
        exp_q.delete();
    endtask

    // One clock: advance to the negedge, then update LFSR and measurement models.
    task automatic cycle();
        @(negedge clk);
        meas_done = 1'b0;
        meas_bit  = 1'b0;
        if (lfsr_enable) begin
            lfsr_m  = {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[1]};
            chal_in = lfsr_m;
            pulse_cnt++;
        end
        if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                meas_done = 1'b1;
                meas_bit  = pend_bit;
            end
        end else if (spurious_en) begin
            meas_done = 1'b1;
            meas_bit  = 1'($urandom_range(0, 1));
        end
        if (meas_start) begin
            check("ro_sel_vs_lfsr", ro_sel, lfsr_m);
            pend_bit = (^ro_sel) ^ inv_cfg;
            asm_word = {asm_word[2:0], (^lfsr_m) ^ inv_cfg};
            asm_n++;
            if (asm_n == 4) begin
                exp_q.push_back(asm_word);
                asm_n = 0;
            end
            if (!mute) countdown = lat_cfg;
        end
    endtask

    task automatic start_run(input logic [3:0] seed);
        lfsr_m    = seed;
        chal_in   = seed;
        pulse_cnt = 0;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
    endtask

    task automatic run_vector(input vec_t v, input int hold, input bit sim_start);
        logic [3:0] exp_w;
        bit         seen;
        lat_cfg     = v.lat;
        inv_cfg     = v.inv;
        spurious_en = v.spur;
        start_run(v.seed);
        check("err_clear_on_start", err, 0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (resp_valid) begin
                seen = 1;
                break;
            end
            cycle();
        end
        check("resp_valid_seen", seen, 1);
        if (seen) begin
            check("sb_depth", exp_q.size(), 1);
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
            check("resp_data_sb", resp_data, exp_w);
            check("resp_data_table", resp_data, v.exp);
            check("lfsr_pulses", pulse_cnt, 4);
            check("err_in_run", err, 0);
            for (int i = 0; i < hold; i++) begin
                start = (i == 3);
                cycle();
                start = 1'b0;
                check("hold_valid", resp_valid, 1);
                check("hold_data", resp_data, v.exp);
            end
            resp_ready = 1'b1;
            start      = sim_start;
            cycle();
            resp_ready = 1'b0;
            start      = 1'b0;
            check("valid_drop", resp_valid, 0);
            check("idle_after_accept", busy, 0);
            cycle();
            check("start_not_seen", busy, 0);
            check("no_extra_pulse", pulse_cnt, 4);
        end else begin
            reset = 1'b1;
            cycle();
            reset = 1'b0;
            reset_model();
        end
        spurious_en = 1'b0;
    endtask

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    // Main sequence.
    initial begin
        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; chal_in = '0; meas_done = 1'b0;
        meas_bit = 1'b0; resp_ready = 1'b0;
        lfsr_m = 4'b0001; lat_cfg = 3; inv_cfg = 0; spurious_en = 0; mute = 0;
        pend_bit = 1'b0;
        reset_model();

        vecs[0] = '{seed: 4'b0001, lat: 3, inv: 0, spur: 0, exp: 4'b1100};
        vecs[1] = '{seed: 4'b1111, lat: 1, inv: 0, spur: 0, exp: 4'b0100};
        vecs[2] = '{seed: 4'b0110, lat: 5, inv: 1, spur: 0, exp: 4'b1001};
        vecs[3] = '{seed: 4'b1000, lat: 2, inv: 0, spur: 1, exp: 4'b1110};
        vecs[4] = '{seed: 4'b0001, lat: 8, inv: 0, spur: 0, exp: 4'b1100};

        cycle();
        cycle();
        check_all_zero("reset_state");
        check("reset_dbg_state", dbg_state, 0);
        reset = 1'b0;
        cycle();

        // Reset in the middle of WAIT.
        lat_cfg = 3; inv_cfg = 0;
        start_run(4'b0001);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (meas_start) begin
                got = 1;
                break;
            end
            cycle();
        end
        check("launch_seen", got, 1);
        cycle();
        check("busy_in_wait", busy, 1);
        reset = 1'b1;
        #1;
        check_all_zero("reset_mid_wait");
        reset_model();
        cycle();
        reset = 1'b0;
        cycle();
        check("post_reset_busy", busy, 0);
        check("post_reset_ro_sel", ro_sel, 0);

        // Table vectors: nominal, latencies, inversion, spurious meas_done, backpressure.
        for (int i = 0; i < 4; i++) begin
            run_vector(vecs[i], (i == 0) ? 10 : 0, i == 0);
        end

        // Reset after two bits, then a fresh run must not see stale bits.
        lat_cfg = 2; inv_cfg = 0;
        start_run(4'b0001);
        got = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (pulse_cnt == 2) begin
                got = 1;
                break;
            end
        end
        check("two_bits_done", got, 1);
        check("busy_mid_run", busy, 1);
        reset = 1'b1;
        #1;
        check_all_zero("reset_after_two");
        reset_model();
        cycle();
        reset = 1'b0;
        cycle();
        run_vector(vecs[1], 0, 0);

        // meas_done arriving in the 8th WAIT cycle.
        run_vector(vecs[4], 0, 0);

`ifdef PUF_TIMEOUT_EN
        // Measurement never answers: timeout after 8 WAIT cycles.
        mute = 1; lat_cfg = 3; inv_cfg = 0;
        start_run(4'b0001);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (meas_start) begin
                got = 1;
                break;
            end
            cycle();
        end
        check("to_launch_seen", got, 1);
        for (int i = 1; i <= 8; i++) begin
            cycle();
            check("to_wait_busy", busy, 1);
        end
        check("to_err_before", err, 0);
        cycle();
        check("to_idle", busy, 0);
        check("to_err_set", err, 1);
        check("to_no_valid", resp_valid, 0);
        cycle();
        check("to_err_sticky", err, 1);
        mute = 0;
        reset_model();
        run_vector(vecs[0], 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
